// File: rtl/riscv_defs.sv
// ----------------------------------------------------------------------------
// riscv_defs.sv
// Purpose : Shared type definitions for the RV32I encoder: the symbolic
//           request opcode (ENC_OP) and the encoder control states.
// Ports   : none (package).
// ----------------------------------------------------------------------------
package riscv_defs;

    // Symbolic op carried on req_op_i; value 7 is reserved as illegal so that
    // every 3-bit pattern maps onto a named member.
    typedef enum logic [2:0] {
        OP_ADD     = 3'd0,
        OP_SLT     = 3'd1,
        OP_ADDI    = 3'd2,
        OP_LW      = 3'd3,
        OP_SW      = 3'd4,
        OP_JAL     = 3'd5,
        OP_BEQ     = 3'd6,
        OP_ILLEGAL = 3'd7
    } ENC_OP;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } ENC_STATE;

endpackage

// File: rtl/riscv_constants.sv
// ----------------------------------------------------------------------------
// riscv_constants.sv
// Purpose : RV32I opcode, funct3 and funct7 field values used by the
//           instruction encoder, plus the canonical NOP word.
// Ports   : none (macro definitions only).
// ----------------------------------------------------------------------------
`ifndef RISCV_CONSTANTS_SV
`define RISCV_CONSTANTS_SV

`define RV_OPC_OP      7'b0110011
`define RV_OPC_OP_IMM  7'b0010011
`define RV_OPC_LOAD    7'b0000011
`define RV_OPC_STORE   7'b0100011
`define RV_OPC_JAL     7'b1101111
`define RV_OPC_BRANCH  7'b1100011

`define RV_F3_ADD      3'b000
`define RV_F3_SLT      3'b010
`define RV_F3_ADDI     3'b000
`define RV_F3_LW       3'b010
`define RV_F3_SW       3'b010
`define RV_F3_BEQ      3'b000

`define RV_F7_BASE     7'b0000000

// addi x0, x0, 0
`define RV_NOP         32'h00000013

`endif

// File: rtl/riscv_inst_pack.sv
// ----------------------------------------------------------------------------
// riscv_inst_pack.sv
// Purpose : Combinational RV32I field packer. Slices the immediate into the
//           R/I/S/B/J layouts and range-checks it. Any illegal op or
//           out-of-range immediate yields bad_o=1 and the NOP word.
// Ports   : op_i   symbolic op (ENC_OP)
//           rd_i, rs1_i, rs2_i  register numbers
//           imm_i  signed immediate (byte offset for JAL/BEQ)
//           word_o encoded instruction
//           bad_o  request could not be encoded
// ----------------------------------------------------------------------------
`ifndef RISCV_CONSTANTS_SV
`include "riscv_constants.sv"
`endif

module riscv_inst_pack
    import riscv_defs::*;
(
    input  ENC_OP       op_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [31:0] imm_i,
    output logic [31:0] word_o,
    output logic        bad_o
);

    logic fits_i;
    logic fits_b;
    logic fits_j;

    // A value fits in an N-bit signed field when every bit above the field's
    // sign bit equals that sign bit. Branch and jump offsets must also be even.
    assign fits_i = (imm_i[31:11] == {21{imm_i[11]}});
    assign fits_b = (imm_i[31:12] == {20{imm_i[12]}}) && !imm_i[0];
    assign fits_j = (imm_i[31:20] == {12{imm_i[20]}}) && !imm_i[0];

    always_comb begin
        word_o = `RV_NOP;
        bad_o  = 1'b0;
        case (op_i)
            OP_ADD:  word_o = {`RV_F7_BASE, rs2_i, rs1_i, `RV_F3_ADD, rd_i, `RV_OPC_OP};
            OP_SLT:  word_o = {`RV_F7_BASE, rs2_i, rs1_i, `RV_F3_SLT, rd_i, `RV_OPC_OP};
            OP_ADDI: begin
                if (fits_i) word_o = {imm_i[11:0], rs1_i, `RV_F3_ADDI, rd_i, `RV_OPC_OP_IMM};
                else        bad_o  = 1'b1;
            end
            OP_LW: begin
                if (fits_i) word_o = {imm_i[11:0], rs1_i, `RV_F3_LW, rd_i, `RV_OPC_LOAD};
                else        bad_o  = 1'b1;
            end
            OP_SW: begin
                if (fits_i) word_o = {imm_i[11:5], rs2_i, rs1_i, `RV_F3_SW, imm_i[4:0], `RV_OPC_STORE};
                else        bad_o  = 1'b1;
            end
            OP_JAL: begin
                if (fits_j) word_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, `RV_OPC_JAL};
                else        bad_o  = 1'b1;
            end
            OP_BEQ: begin
                if (fits_b) word_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, `RV_F3_BEQ,
                                      imm_i[4:1], imm_i[11], `RV_OPC_BRANCH};
                else        bad_o  = 1'b1;
            end
            default: bad_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/riscv_inst_encoder.sv
// ----------------------------------------------------------------------------
// riscv_inst_encoder.sv
// Purpose : Streaming RV32I encoder used by the program loader. Accepts
//           symbolic requests over valid/ready and writes the encoded words
//           to instruction memory at base, base+4, base+8, ...
// Ports   : clk, rst_n                 clock, async active-low reset
//           start_i, base_addr_i       begin a program (IDLE only), first address
//           req_valid_i/req_ready_o    request handshake
//           req_op_i, req_rd_i, req_rs1_i, req_rs2_i, req_imm_i, req_last_i
//           wr_valid_o/wr_ready_i      imem write handshake
//           wr_addr_o, wr_data_o       imem write address / encoded word
//           busy_o, done_o             not idle / one-cycle completion pulse
//           err_o, err_addr_o          sticky error flag / first bad word address
//           word_cnt_o                 requests accepted since start
// ----------------------------------------------------------------------------
module riscv_inst_encoder
    import riscv_defs::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [2:0]        req_op_i,
    input  logic [4:0]        req_rd_i,
    input  logic [4:0]        req_rs1_i,
    input  logic [4:0]        req_rs2_i,
    input  logic [31:0]       req_imm_i,
    input  logic              req_last_i,
    output logic              wr_valid_o,
    input  logic              wr_ready_i,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [31:0]       wr_data_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [ADDR_W-1:0] err_addr_o,
    output logic [CNT_W-1:0]  word_cnt_o
);

    ENC_STATE          state_q,    state_d;
    logic [ADDR_W-1:0] base_q,     base_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;
    logic              wr_valid_q, wr_valid_d;
    logic [ADDR_W-1:0] wr_addr_q,  wr_addr_d;
    logic [31:0]       wr_data_q,  wr_data_d;
    logic              err_q,      err_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;
    logic              done_q,     done_d;

    logic              req_ready;
    logic              accept;
    logic              out_free;
    logic [ADDR_W-1:0] next_addr;
    logic [31:0]       pack_word;
    logic              pack_bad;

    riscv_inst_pack u_pack (
        .op_i   (ENC_OP'(req_op_i)),
        .rd_i   (req_rd_i),
        .rs1_i  (req_rs1_i),
        .rs2_i  (req_rs2_i),
        .imm_i  (req_imm_i),
        .word_o (pack_word),
        .bad_o  (pack_bad)
    );

    // The single output register can take a new word when it is empty or is
    // being drained this cycle, so a steady stream has no bubbles.
    assign out_free  = !wr_valid_q || wr_ready_i;
    assign req_ready = (state_q == ST_RUN) && out_free;
    assign accept    = req_valid_i && req_ready;

    // Counter is zero-extended before the shift so both wraps are modular.
    assign next_addr = base_q + (ADDR_W'(cnt_q) << 2);

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        cnt_d      = cnt_q;
        wr_valid_d = wr_valid_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        err_d      = err_q;
        err_addr_d = err_addr_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d    = ST_RUN;
                    base_d     = base_addr_i;
                    cnt_d      = '0;
                    err_d      = 1'b0;
                    err_addr_d = '0;
                end
            end
            ST_RUN: begin
                if (accept && req_last_i) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (out_free) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (wr_valid_q && wr_ready_i) wr_valid_d = 1'b0;

        // A bad request still occupies its slot (as a NOP) so later addresses
        // stay aligned with the request stream.
        if (accept) begin
            wr_valid_d = 1'b1;
            wr_addr_d  = next_addr;
            wr_data_d  = pack_word;
            cnt_d      = cnt_q + CNT_W'(1);
            if (pack_bad) begin
                err_d = 1'b1;
                if (!err_q) err_addr_d = next_addr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            base_q     <= '0;
            cnt_q      <= '0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            cnt_q      <= cnt_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
            done_q     <= done_d;
        end
    end

    assign req_ready_o = req_ready;
    assign wr_valid_o  = wr_valid_q;
    assign wr_addr_o   = wr_addr_q;
    assign wr_data_o   = wr_data_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign err_addr_o  = err_addr_q;
    assign word_cnt_o  = cnt_q;

endmodule

// File: tb/tb_riscv_inst_encoder.sv
// ----------------------------------------------------------------------------
// tb_riscv_inst_encoder.sv
// Purpose : Self-checking bench for riscv_inst_encoder. Table-driven programs
//           with hand-computed words, directed stall/reset sequences, and a
//           randomized program checked against an arithmetic reference encoder.
// ----------------------------------------------------------------------------
module tb_riscv_inst_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic [31:0] base_addr_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [2:0]  req_op_i;
    logic [4:0]  req_rd_i;
    logic [4:0]  req_rs1_i;
    logic [4:0]  req_rs2_i;
    logic [31:0] req_imm_i;
    logic        req_last_i;
    logic        wr_valid_o;
    logic        wr_ready_i;
    logic [31:0] wr_addr_o;
    logic [31:0] wr_data_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic [31:0] err_addr_o;
    logic [15:0] word_cnt_o;

    riscv_inst_encoder #(.ADDR_W(32), .CNT_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_op_i    (req_op_i),
        .req_rd_i    (req_rd_i),
        .req_rs1_i   (req_rs1_i),
        .req_rs2_i   (req_rs2_i),
        .req_imm_i   (req_imm_i),
        .req_last_i  (req_last_i),
        .wr_valid_o  (wr_valid_o),
        .wr_ready_i  (wr_ready_i),
        .wr_addr_o   (wr_addr_o),
        .wr_data_o   (wr_data_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .err_addr_o  (err_addr_o),
        .word_cnt_o  (word_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        last;
        logic [31:0] expWord;
        logic        expBad;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    int          errors = 0;
    int          checks = 0;
    wr_t         expQ[$];
    logic [31:0] mBase = '0;
    logic [15:0] mCnt = '0;
    logic        mErr = 1'b0;
    logic [31:0] mErrAddr = '0;
    int          lastWait = 0;
    bit          randStall = 1'b0;
    int          stallEnd = 0;
    int          cycleNo = 0;
    bit          holdValid = 1'b0;
    logic [31:0] holdAddr;
    logic [31:0] holdData;
    wr_t         monEntry;

    vec_t prog1[7];
    vec_t prog2[15];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference encoder: field placement by shifting and masking plain
    // integers, range checks on the signed value.
    function automatic logic [32:0] refEncode(input logic [2:0] op, input logic [4:0] rd,
                                              input logic [4:0] rs1, input logic [4:0] rs2,
                                              input logic [31:0] imm);
        int          s;
        logic [31:0] d;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] w;
        bit          bad;
        s   = $signed(imm);
        d   = 32'(rd) << 7;
        a   = 32'(rs1) << 15;
        b   = 32'(rs2) << 20;
        bad = 1'b0;
        w   = 32'h0;
        case (op)
            3'd0: w = 32'h33 | d | a | b;
            3'd1: w = 32'h33 | (32'd2 << 12) | d | a | b;
            3'd2: begin
                bad = (s < -2048) || (s > 2047);
                w = 32'h13 | d | a | ((imm & 32'hFFF) << 20);
            end
            3'd3: begin
                bad = (s < -2048) || (s > 2047);
                w = 32'h03 | (32'd2 << 12) | d | a | ((imm & 32'hFFF) << 20);
            end
            3'd4: begin
                bad = (s < -2048) || (s > 2047);
                w = 32'h23 | (32'd2 << 12) | a | b | ((imm & 32'h1F) << 7)
                    | (((imm >> 5) & 32'h7F) << 25);
            end
            3'd5: begin
                bad = imm[0] || (s < -(1 << 20)) || (s > (1 << 20) - 2);
                w = 32'h6F | d | (((imm >> 12) & 32'hFF) << 12) | (((imm >> 11) & 32'h1) << 20)
                    | (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 20) & 32'h1) << 31);
            end
            3'd6: begin
                bad = imm[0] || (s < -4096) || (s > 4094);
                w = 32'h63 | a | b | (((imm >> 11) & 32'h1) << 7) | (((imm >> 1) & 32'hF) << 8)
                    | (((imm >> 5) & 32'h3F) << 25) | (((imm >> 12) & 32'h1) << 31);
            end
            default: bad = 1'b1;
        endcase
        if (bad) w = 32'h13;
        return {bad, w};
    endfunction

    // Memory-side monitor: drives wr_ready_i for the coming edge, then checks
    // every completed write against the expected stream and checks that a
    // stalled word does not change.
    always @(negedge clk) begin
        cycleNo++;
        if (randStall) wr_ready_i = ($urandom_range(0, 3) != 0);
        else           wr_ready_i = (cycleNo > stallEnd);
        #1;
        if (!rst_n) begin
            holdValid = 1'b0;
        end else begin
            if (holdValid) begin
                checkOutput("holdValid", 32'(wr_valid_o), 32'd1);
                checkOutput("holdAddr", wr_addr_o, holdAddr);
                checkOutput("holdData", wr_data_o, holdData);
            end
            if (wr_valid_o && wr_ready_i) begin
                holdValid = 1'b0;
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpectedWrite: got addr 0x%08h data 0x%08h, expected no write",
                             wr_addr_o, wr_data_o);
                end else begin
                    monEntry = expQ.pop_front();
                    checkOutput("wrAddr", wr_addr_o, monEntry.addr);
                    checkOutput("wrData", wr_data_o, monEntry.data);
                end
            end else if (wr_valid_o) begin
                holdValid = 1'b1;
                holdAddr  = wr_addr_o;
                holdData  = wr_data_o;
            end else begin
                holdValid = 1'b0;
            end
        end
    end

    task automatic startProgram(input logic [31:0] base);
        @(negedge clk);
        base_addr_i = base;
        start_i     = 1'b1;
        @(posedge clk);
        #1;
        start_i     = 1'b0;
        base_addr_i = ~base;
        mBase    = base;
        mCnt     = '0;
        mErr     = 1'b0;
        mErrAddr = '0;
        checkOutput("startBusy", 32'(busy_o), 32'd1);
        checkOutput("startErr", 32'(err_o), 32'd0);
        checkOutput("startErrAddr", err_addr_o, 32'd0);
        checkOutput("startCnt", 32'(word_cnt_o), 32'd0);
    endtask

    task automatic applyStimulus(input vec_t v);
        int          waitCnt;
        logic [31:0] addr;
        waitCnt = 0;
        @(negedge clk);
        req_valid_i = 1'b1;
        req_op_i    = v.op;
        req_rd_i    = v.rd;
        req_rs1_i   = v.rs1;
        req_rs2_i   = v.rs2;
        req_imm_i   = v.imm;
        req_last_i  = v.last;
        #2;
        while (!req_ready_o && waitCnt < 100) begin
            @(negedge clk);
            #2;
            waitCnt++;
        end
        lastWait = waitCnt;
        if (!req_ready_o) begin
            checks++;
            errors++;
            $display("[TB] FAIL acceptTimeout: got req_ready_o=0 after %0d cycles, expected 1", waitCnt);
            req_valid_i = 1'b0;
            req_last_i  = 1'b0;
        end else begin
            addr = mBase + {14'b0, mCnt, 2'b00};
            expQ.push_back('{addr, v.expWord});
            if (v.expBad && !mErr) mErrAddr = addr;
            if (v.expBad) mErr = 1'b1;
            mCnt = mCnt + 16'd1;
            @(posedge clk);
            #1;
            req_valid_i = 1'b0;
            req_last_i  = 1'b0;
            checkOutput("wordCnt", 32'(word_cnt_o), 32'(mCnt));
            checkOutput("errFlag", 32'(err_o), 32'(mErr));
        end
    endtask

    task automatic finishProgram(input int maxCycles);
        int n;
        n = 0;
        while (!done_o && n < maxCycles) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("donePulse", 32'(done_o), 32'd1);
        checkOutput("doneBusy", 32'(busy_o), 32'd0);
        checkOutput("pendingWrites", 32'(expQ.size()), 32'd0);
        checkOutput("finalCnt", 32'(word_cnt_o), 32'(mCnt));
        checkOutput("finalErr", 32'(err_o), 32'(mErr));
        checkOutput("finalErrAddr", err_addr_o, mErrAddr);
        @(posedge clk);
        #1;
        checkOutput("doneOnce", 32'(done_o), 32'd0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "Busy"}, 32'(busy_o), 32'd0);
        checkOutput({tag, "ReqReady"}, 32'(req_ready_o), 32'd0);
        checkOutput({tag, "WrValid"}, 32'(wr_valid_o), 32'd0);
        checkOutput({tag, "WrAddr"}, wr_addr_o, 32'd0);
        checkOutput({tag, "WrData"}, wr_data_o, 32'd0);
        checkOutput({tag, "Done"}, 32'(done_o), 32'd0);
        checkOutput({tag, "Err"}, 32'(err_o), 32'd0);
        checkOutput({tag, "ErrAddr"}, err_addr_o, 32'd0);
        checkOutput({tag, "Cnt"}, 32'(word_cnt_o), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t v;
        logic [32:0] enc;

        // op, rd, rs1, rs2, imm, last, expected word, expected bad
        prog1[0] = '{3'd0, 5'd1,  5'd2,  5'd3,  32'd0,         1'b0, 32'h003100B3, 1'b0};
        prog1[1] = '{3'd2, 5'd1,  5'd0,  5'd0,  32'd5,         1'b0, 32'h00500093, 1'b0};
        prog1[2] = '{3'd4, 5'd0,  5'd1,  5'd2,  32'd8,         1'b0, 32'h0020A423, 1'b0};
        prog1[3] = '{3'd1, 5'd5,  5'd6,  5'd7,  32'd0,         1'b0, 32'h007322B3, 1'b0};
        prog1[4] = '{3'd3, 5'd10, 5'd11, 5'd0,  32'hFFFFFFFC,  1'b0, 32'hFFC5A503, 1'b0};
        prog1[5] = '{3'd6, 5'd0,  5'd1,  5'd2,  32'hFFFFFFFC,  1'b0, 32'hFE208EE3, 1'b0};
        prog1[6] = '{3'd5, 5'd1,  5'd0,  5'd0,  32'd8,         1'b1, 32'h008000EF, 1'b0};

        prog2[0]  = '{3'd2, 5'd1,  5'd1,  5'd31, 32'd2047,       1'b0, 32'h7FF08093, 1'b0};
        prog2[1]  = '{3'd2, 5'd1,  5'd1,  5'd31, 32'd2048,       1'b0, 32'h00000013, 1'b1};
        prog2[2]  = '{3'd7, 5'd1,  5'd2,  5'd3,  32'd0,          1'b0, 32'h00000013, 1'b1};
        prog2[3]  = '{3'd2, 5'd1,  5'd1,  5'd31, 32'hFFFFF800,   1'b0, 32'h80008093, 1'b0};
        prog2[4]  = '{3'd2, 5'd1,  5'd1,  5'd0,  32'hFFFFF7FF,   1'b0, 32'h00000013, 1'b1};
        prog2[5]  = '{3'd6, 5'd31, 5'd0,  5'd0,  32'd4094,       1'b0, 32'h7E000FE3, 1'b0};
        prog2[6]  = '{3'd6, 5'd31, 5'd0,  5'd0,  32'hFFFFF000,   1'b0, 32'h80000063, 1'b0};
        prog2[7]  = '{3'd6, 5'd0,  5'd0,  5'd0,  32'd4096,       1'b0, 32'h00000013, 1'b1};
        prog2[8]  = '{3'd6, 5'd0,  5'd0,  5'd0,  32'd3,          1'b0, 32'h00000013, 1'b1};
        prog2[9]  = '{3'd5, 5'd0,  5'd31, 5'd31, 32'h000FFFFE,   1'b0, 32'h7FFFF06F, 1'b0};
        prog2[10] = '{3'd5, 5'd0,  5'd31, 5'd31, 32'hFFF00000,   1'b0, 32'h8000006F, 1'b0};
        prog2[11] = '{3'd5, 5'd0,  5'd0,  5'd0,  32'h00100000,   1'b0, 32'h00000013, 1'b1};
        prog2[12] = '{3'd5, 5'd0,  5'd0,  5'd0,  32'd7,          1'b0, 32'h00000013, 1'b1};
        prog2[13] = '{3'd4, 5'd9,  5'd4,  5'd3,  32'hFFFFFFFF,   1'b0, 32'hFE322FA3, 1'b0};
        prog2[14] = '{3'd4, 5'd0,  5'd4,  5'd3,  32'd2048,       1'b1, 32'h00000013, 1'b1};

        rst_n       = 1'b0;
        start_i     = 1'b0;
        base_addr_i = '0;
        req_valid_i = 1'b0;
        req_op_i    = '0;
        req_rd_i    = '0;
        req_rs1_i   = '0;
        req_rs2_i   = '0;
        req_imm_i   = '0;
        req_last_i  = 1'b0;

        #3;
        checkAllZero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idleReady", 32'(req_ready_o), 32'd0);

        $display("[TB] spec program at 0x100, back-to-back");
        startProgram(32'h00000100);
        foreach (prog1[i]) begin
            applyStimulus(prog1[i]);
            checkOutput("noBubble", 32'(lastWait), 32'd0);
        end
        finishProgram(20);

        $display("[TB] immediate boundaries and illegal op at 0x800");
        startProgram(32'h00000800);
        foreach (prog2[i]) applyStimulus(prog2[i]);
        finishProgram(20);
        checkOutput("errAddrFirstBad", err_addr_o, 32'h00000804);
        checkOutput("errStickyIdle", 32'(err_o), 32'd1);

        $display("[TB] write-side stall at 0x2000");
        startProgram(32'h00002000);
        applyStimulus(prog1[0]);
        stallEnd    = cycleNo + 5;
        req_valid_i = 1'b1;
        req_op_i    = prog1[1].op;
        req_rd_i    = prog1[1].rd;
        req_rs1_i   = prog1[1].rs1;
        req_rs2_i   = prog1[1].rs2;
        req_imm_i   = prog1[1].imm;
        repeat (5) begin
            @(negedge clk);
            #2;
            checkOutput("stallReady", 32'(req_ready_o), 32'd0);
            checkOutput("stallWrValid", 32'(wr_valid_o), 32'd1);
            checkOutput("stallCnt", 32'(word_cnt_o), 32'd1);
        end
        applyStimulus(prog1[1]);
        checkOutput("afterStall", 32'(lastWait), 32'd0);
        v = prog1[2];
        v.last = 1'b1;
        applyStimulus(v);
        finishProgram(20);

        $display("[TB] randomized program wrapping the address space");
        randStall = 1'b1;
        startProgram(32'hFFFFFF00);
        for (int i = 0; i < 80; i++) begin
            v.op  = 3'($urandom_range(0, 7));
            v.rd  = 5'($urandom);
            v.rs1 = 5'($urandom);
            v.rs2 = 5'($urandom);
            case ($urandom_range(0, 3))
                0:       v.imm = 32'($urandom_range(0, 4095)) - 32'd2048;
                1:       v.imm = 32'($urandom_range(0, 8191)) - 32'd4096;
                2:       v.imm = 32'($urandom_range(0, 32'h1FFFFF)) - 32'h00100000;
                default: v.imm = $urandom;
            endcase
            v.last = (i == 79);
            enc = refEncode(v.op, v.rd, v.rs1, v.rs2, v.imm);
            v.expBad  = enc[32];
            v.expWord = enc[31:0];
            applyStimulus(v);
        end
        finishProgram(300);
        randStall = 1'b0;

        $display("[TB] asynchronous reset in RUN, then clean restart");
        startProgram(32'h00003000);
        applyStimulus(prog1[0]);
        applyStimulus(prog1[3]);
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkAllZero("midReset");
        expQ.delete();
        @(negedge clk);
        rst_n = 1'b1;
        startProgram(32'h00004000);
        v = prog1[0];
        v.last = 1'b1;
        applyStimulus(v);
        finishProgram(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
